// File: rtl/motor_serial_rx.sv
// 8N1 serial receiver that decodes each good byte into signed speed commands for two motors.
// Optional link watchdog is compiled in with `define MOTOR_RX_WATCHDOG_EN.
`timescale 1ns/1ps
module motor_serial_rx #(
  parameter int unsigned CLK_FREQ       = 50_000_000,
  parameter int unsigned BAUD           = 9600,
  parameter int unsigned TIMEOUT_CYCLES = 25_000_000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              uart_in,
  output logic              byte_valid,
  output logic [7:0]        byte_data,
  output logic              frame_err,
  output logic signed [6:0] m1_speed,
  output logic signed [6:0] m2_speed,
  output logic              link_ok
);

  localparam int unsigned CPB  = CLK_FREQ / BAUD;
  localparam int unsigned HALF = CPB / 2;
  localparam int unsigned CW   = $clog2(CPB) + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT} state_e;

  state_e            state_q, state_d;
  logic              sync1_q, sync2_q, prev_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              byte_valid_q, frame_err_q, link_q, link_d;
  logic [7:0]        byte_data_q;
  logic signed [6:0] m1_q, m1_d, m2_q, m2_d;
  logic              tick, good_frame, bad_frame;
  logic [7:0]        diff1, diff2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      sync1_q <= uart_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Start bit is checked at its midpoint; every later bit one full bit period on.
  assign tick = (state_q == S_START) ? (cnt_q == CW'(HALF)) : (cnt_q == CW'(CPB - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync2_q) state_d = S_START;
      end
      S_START: if (tick) begin
        cnt_d   = '0;
        bit_d   = '0;
        state_d = sync2_q ? S_IDLE : S_DATA;
      end
      S_DATA: if (tick) begin
        cnt_d   = '0;
        shift_d = {sync2_q, shift_q[7:1]};
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = S_STOP;
      end
      S_STOP: if (tick) begin
        cnt_d   = '0;
        state_d = sync2_q ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        cnt_d = '0;
        if (sync2_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign good_frame = (state_q == S_STOP) && tick && sync2_q;
  assign bad_frame  = (state_q == S_STOP) && tick && !sync2_q;
  assign diff1      = shift_q - 8'd64;
  assign diff2      = shift_q - 8'd192;

`ifdef MOTOR_RX_WATCHDOG_EN
  localparam int unsigned SW = $clog2(TIMEOUT_CYCLES + 1);
  logic [SW-1:0] sil_q, sil_d;
  logic          timeout;

  assign timeout = (sil_q == SW'(TIMEOUT_CYCLES - 1));
  assign sil_d   = good_frame ? '0 : (timeout ? sil_q : sil_q + SW'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sil_q <= '0;
    else          sil_q <= sil_d;
  end
`endif

  always_comb begin
    m1_d   = m1_q;
    m2_d   = m2_q;
    link_d = link_q;
`ifdef MOTOR_RX_WATCHDOG_EN
    if (timeout) begin
      m1_d   = '0;
      m2_d   = '0;
      link_d = 1'b0;
    end
`endif
    if (good_frame) begin
      link_d = 1'b1;
      if (shift_q == 8'h00) begin
        m1_d = '0;
        m2_d = '0;
      end else if (!shift_q[7]) begin
        m1_d = diff1[6:0];
      end else begin
        m2_d = diff2[6:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      byte_data_q  <= '0;
      m1_q         <= '0;
      m2_q         <= '0;
      link_q       <= 1'b0;
    end else begin
      byte_valid_q <= good_frame;
      frame_err_q  <= bad_frame;
      if (good_frame) byte_data_q <= shift_q;
      m1_q         <= m1_d;
      m2_q         <= m2_d;
      link_q       <= link_d;
    end
  end

  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;
  assign byte_data  = byte_data_q;
  assign m1_speed   = m1_q;
  assign m2_speed   = m2_q;
  assign link_ok    = link_q;

endmodule

// File: tb/tb_motor_serial_rx.sv
// Directed plus randomized bench for motor_serial_rx with a byte-level reference model.
`timescale 1ns/1ps
module tb_motor_serial_rx;
  localparam int unsigned CLK_FREQ = 1_600_000;
  localparam int unsigned BAUD     = 100_000;
  localparam int unsigned TIMEOUT  = 2000;
  localparam int          CPB      = 16;
`ifdef MOTOR_RX_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              uart_in = 1'b1;
  logic              byte_valid, frame_err, link_ok;
  logic [7:0]        byte_data;
  logic signed [6:0] m1_speed, m2_speed;

  motor_serial_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .uart_in(uart_in),
    .byte_valid(byte_valid), .byte_data(byte_data), .frame_err(frame_err),
    .m1_speed(m1_speed), .m2_speed(m2_speed), .link_ok(link_ok)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int bv_cnt = 0, fe_cnt = 0, both_cnt = 0;

  // pulse-width monitor: each frame must give exactly one high cycle
  always @(negedge clk) begin
    if (reset_n) begin
      if (byte_valid) bv_cnt++;
      if (frame_err) fe_cnt++;
      if (byte_valid && frame_err) both_cnt++;
    end
  end

  // reference model state
  int         exp_m1 = 0, exp_m2 = 0, exp_link = 0, exp_bv = 0, exp_fe = 0;
  logic [7:0] exp_bd = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  function automatic logic [31:0] sx7(input logic [6:0] v);
    return {{25{v[6]}}, v};
  endfunction

  task automatic check_all(input string tag);
    check({tag, "/byte_data"}, 32'(byte_data), 32'(exp_bd));
    check({tag, "/m1"}, sx7(m1_speed), 32'(exp_m1));
    check({tag, "/m2"}, sx7(m2_speed), 32'(exp_m2));
    check({tag, "/link"}, 32'(link_ok), 32'(exp_link));
    check({tag, "/valid_pulses"}, 32'(bv_cnt), 32'(exp_bv));
    check({tag, "/err_pulses"}, 32'(fe_cnt), 32'(exp_fe));
    check({tag, "/both_high"}, 32'(both_cnt), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "/byte_valid"}, 32'(byte_valid), 32'd0);
    check({tag, "/frame_err"}, 32'(frame_err), 32'd0);
    check({tag, "/byte_data"}, 32'(byte_data), 32'd0);
    check({tag, "/m1"}, sx7(m1_speed), 32'd0);
    check({tag, "/m2"}, sx7(m2_speed), 32'd0);
    check({tag, "/link"}, 32'(link_ok), 32'd0);
  endtask

  task automatic line(input logic v, input int n);
    uart_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    line(1'b1, n);
    if (WD && n >= int'(TIMEOUT)) begin
      exp_m1 = 0; exp_m2 = 0; exp_link = 0;
    end
  endtask

  // stop_low > 0 holds the stop bit low that many cycles before releasing the line
  task automatic send(input logic [7:0] b, input int stop_low);
    line(1'b0, CPB);
    for (int i = 0; i < 8; i++) line(b[i], CPB);
    if (stop_low > 0) begin
      line(1'b0, stop_low);
      exp_fe++;
    end else begin
      exp_bd = b; exp_link = 1; exp_bv++;
      if (b == 8'h00) begin
        exp_m1 = 0; exp_m2 = 0;
      end else if (b < 8'h80) exp_m1 = int'(b) - 64;
      else exp_m2 = int'(b) - 192;
    end
    line(1'b1, CPB);
  endtask

  initial begin
    logic [7:0] rb;
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    idle(5);

    send(8'h7F, 0); idle(3);
    check_all("t1_7F");

    send(8'h80, 0);
    check_all("t2_80");
    send(8'hC0, 0); idle(3);
    check_all("t2_C0");

    send(8'h40, 0); idle(2);
    check_all("t3_40");
    send(8'hFF, 0); idle(2);
    check_all("t3_FF");
    send(8'h00, 0); idle(2);
    check_all("t3_00");

    send(8'h25, 40); idle(4);
    check_all("t4_ferr");
    send(8'h30, 0); idle(3);
    check_all("t4_30");

    line(1'b0, 5); idle(40);
    check_all("t5_glitch");
    line(1'b0, CPB);
    for (int i = 0; i < 3; i++) line(1'b1, CPB);
    line(1'b1, 7);
    reset_n = 1'b0;
    #1;
    check_zero("t5_reset_mid");
    exp_m1 = 0; exp_m2 = 0; exp_link = 0; exp_bd = 8'h00;
    uart_in = 1'b1;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    idle(5);
    check_all("t5_after_reset");
    send(8'h10, 0); idle(3);
    check_all("t5_10");

    for (int k = 0; k < 14; k++) begin
      rb = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 4) == 0) send(rb, 20 + int'($urandom_range(0, 20)));
      else send(rb, 0);
      idle(2 + int'($urandom_range(0, 20)));
      check_all("rand");
    end

    send(8'h7F, 0); idle(3);
    check_all("t6_7F");
    idle(int'(TIMEOUT) + 100);
    check_all("t6_silence");
    send(8'h50, 0); idle(3);
    check_all("t6_50");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
